// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian request controller.
// Detects rising edges of the debounced button level and raises a held
// request to the phase FSM. The request is tracked through grant and
// walk completion. After each walk, a hold-off window defers any new request.
// Optional feature: define PED_PRESS_COUNT_EN to build the saturating
// press counter. Without it, press_count is tied to zero.
module ped_request_ctrl #(
    parameter int HOLDOFF_CYCLES = 100,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_state,
    input  logic             grant,
    input  logic             walk_done,
    output logic             req,
    output logic             busy,
    output logic             press_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0] HO_LOAD =
        (HOLDOFF_CYCLES > 0) ? HO_W'(HOLDOFF_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLDOFF} state_t;

    state_t          state;
    state_t          state_nx;
    logic            prev;
    logic            rise;
    logic            early;
    logic [HO_W-1:0] ho_cnt;

    // prev resets to 1, so a button held through reset release is not a press.
    assign rise = button_state & ~prev;

    // Edge detector: remember last level and register the rise as a pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev        <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            prev        <= button_state;
            press_pulse <= rise;
        end
    end

    // Next-state decision; grant wins over walk_done because REQ only looks at grant
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rise)  state_nx = REQ;
            REQ:     if (grant) state_nx = SERVE;
            SERVE:   if (walk_done) state_nx = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            // A rise landing on the final hold-off cycle is deferred, not lost
            HOLDOFF: if (ho_cnt == '0) state_nx = (early | rise) ? REQ : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase FSM with registered req/busy derived from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req    <= 1'b0;
            busy   <= 1'b0;
            early  <= 1'b0;
            ho_cnt <= '0;
        end else begin
            state <= state_nx;
            req   <= (state_nx == REQ);
            busy  <= (state_nx != IDLE);

            if (state == SERVE && walk_done) begin
                ho_cnt <= HO_LOAD;
            end else if (state == HOLDOFF && ho_cnt != '0) begin
                ho_cnt <= ho_cnt - HO_W'(1);
            end

            if (state == HOLDOFF) begin
                early <= (ho_cnt == '0) ? 1'b0 : (early | rise);
            end
        end
    end

`ifdef PED_PRESS_COUNT_EN
    // Saturating press counter, stepping on the same edge as press_pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count <= '0;
        end else if (rise && press_count != '1) begin
            press_count <= press_count + CNT_W'(1);
        end
    end
`else
    assign press_count = '0;
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Testbench for ped_request_ctrl.
// A phase-level reference model tracks the absolute cycle at which hold-off
// ends. A compare process checks every output on every falling edge.
// Directed sections pin the model with literal expectations. These cover the
// idle press, the full cycle, deferral, ignored events, reset cases and
// counter saturation. A randomized section then runs.
module tb_ped_request_ctrl;

    localparam int HO = 100;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button_state = 1'b0;
    logic          grant = 1'b0;
    logic          walk_done = 1'b0;
    logic          req;
    logic          busy;
    logic          press_pulse;
    logic [CW-1:0] press_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ped_request_ctrl #(.HOLDOFF_CYCLES(HO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .button_state (button_state),
        .grant        (grant),
        .walk_done    (walk_done),
        .req          (req),
        .busy         (busy),
        .press_pulse  (press_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 requesting, 2 serving, 3 hold-off
    int     m_phase = 0;
    longint m_t     = 0;
    longint m_exit  = 0;
    bit     m_def   = 1'b0;
    bit     m_prev  = 1'b1;
    bit     m_pulse = 1'b0;
    bit     m_rise  = 1'b0;
    int     m_cnt   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_def   = 1'b0;
            m_prev  = 1'b1;
            m_pulse = 1'b0;
            m_cnt   = 0;
        end else begin
            m_t++;
            m_rise  = button_state && !m_prev;
            m_prev  = button_state;
            m_pulse = m_rise;
            if (m_rise && m_cnt < (1 << CW) - 1) m_cnt++;
            case (m_phase)
                0: if (m_rise) m_phase = 1;
                1: if (grant) m_phase = 2;
                2: if (walk_done) begin
                    if (HO == 0) m_phase = 0;
                    else begin
                        m_phase = 3;
                        m_exit  = m_t + HO;
                    end
                end
                default: begin
                    if (m_rise) m_def = 1'b1;
                    if (m_t == m_exit) begin
                        m_phase = m_def ? 1 : 0;
                        m_def   = 1'b0;
                    end
                end
            endcase
        end
    end

    function automatic int exp_count();
`ifdef PED_PRESS_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_req",   int'(req),         int'(m_phase == 1));
            chk("cmp_busy",  int'(busy),        int'(m_phase != 0));
            chk("cmp_pulse", int'(press_pulse), int'(m_pulse));
            chk("cmp_count", int'(press_count), exp_count());
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int npulse;
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 3, 3};

        // Reset with the button held high
        button_state = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) cyc();
        chk("rst_req",   int'(req), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_pulse", int'(press_pulse), 0);
        chk("rst_count", int'(press_count), 0);
        reset = 1'b1;
        repeat (3) begin
            cyc();
            chk("held_thru_reset_pulse", int'(press_pulse), 0);
            chk("held_thru_reset_busy",  int'(busy), 0);
        end
        button_state = 1'b0;
        cyc();

        // grant in IDLE is ignored
        grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("grant_in_idle_busy", int'(busy), 0);

        // Idle press held 50 cycles gives exactly one pulse
        repeat (10) cyc();
        button_state = 1'b1;
        cyc();
        chk("idle_press_pulse", int'(press_pulse), 1);
        chk("idle_press_req",   int'(req), 1);
        chk("idle_press_busy",  int'(busy), 1);
        npulse = 0;
        repeat (49) begin
            cyc();
            if (press_pulse) npulse++;
        end
        chk("held_press_extra_pulses", npulse, 0);
        button_state = 1'b0;
        cyc();

        // walk_done in REQ is ignored, then grant plus walk_done goes to SERVE
        walk_done = 1'b1;
        cyc();
        walk_done = 1'b0;
        chk("wd_in_req_req", int'(req), 1);
        grant = 1'b1;
        walk_done = 1'b1;
        cyc();
        grant = 1'b0;
        walk_done = 1'b0;
        chk("grant_wd_req",  int'(req), 0);
        chk("grant_wd_busy", int'(busy), 1);
        repeat (19) cyc();
        walk_done = 1'b1;
        cyc();
        walk_done = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            cyc();
        end
        chk("holdoff_busy_len", n, 100);

        // Full cycle with a press deferred from hold-off cycle 30
        button_state = 1'b1;
        cyc();
        chk("cycle2_req", int'(req), 1);
        button_state = 1'b0;
        repeat (4) cyc();
        grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("req_falls_after_grant", int'(req), 0);
        repeat (19) cyc();
        walk_done = 1'b1;
        cyc();
        walk_done = 1'b0;
        n = 0;
        while (!req && n < 300) begin
            n++;
            if (n == 30) button_state = 1'b1;
            if (n == 33) button_state = 1'b0;
            cyc();
        end
        chk("deferral_req_delay", n, 100);
        chk("deferral_busy", int'(busy), 1);

        // Asynchronous reset while in SERVE
        grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("serve_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req",   int'(req), 0);
        chk("async_rst_busy",  int'(busy), 0);
        chk("async_rst_pulse", int'(press_pulse), 0);
        chk("async_rst_count", int'(press_count), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // Five distinct presses against the saturating counter
        for (int i = 0; i < 5; i++) begin
            button_state = 1'b1;
            cyc();
`ifdef PED_PRESS_COUNT_EN
            chk("press_count_seq", int'(press_count), exp_seq[i]);
`else
            chk("press_count_off", int'(press_count), 0);
`endif
            button_state = 1'b0;
            cyc();
        end

        // Randomized traffic, occasionally interrupted by reset
        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) button_state = ~button_state;
            grant     = ($urandom_range(0, 5) == 0);
            walk_done = ($urandom_range(0, 5) == 0);
            cyc();
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
        end
        grant = 1'b0;
        walk_done = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
